lcd_text_sequencer: RTL and testbench



---
 rtl/lcd_text_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_lcd_text_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_text_sequencer
// Brief    : Streams N-message 2-line text from a sync ROM into the HD44780
//            controller; BCD digits replace FIELD_CHAR placeholders.
//            Define LCD_LZ_BLANK_EN to blank leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_text_sequencer #(
    parameter int          N_MSG      = 4,
    parameter int          COLS       = 16,
    parameter int          DIGITS     = 4,
    parameter logic [7:0]  FIELD_CHAR = 8'h01,
    parameter int          BUSY_TO    = 15,
    parameter int          GAP        = 1000,
    localparam int         MSG_W      = (N_MSG > 1) ? $clog2(N_MSG) : 1,
    localparam int         ADDR_W     = $clog2(N_MSG*2*COLS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lcd_busy,
    input  logic [MSG_W-1:0]      msg_sel,
    input  logic [4*DIGITS-1:0]   value_bcd,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [7:0]            rom_data,
    output logic                  lcd_ena,
    output logic [9:0]            lcd_bus,
    output logic                  frame_done
);

    localparam int c_IDX_W = $clog2(2*COLS+2);
    localparam int c_PTR_W = $clog2(DIGITS+1);
    localparam int c_TO_W  = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
    localparam int c_GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [c_IDX_W-1:0] c_CMD2     = c_IDX_W'(COLS+1);
    localparam logic [c_IDX_W-1:0] c_LAST     = c_IDX_W'(2*COLS+1);
    localparam logic [c_PTR_W-1:0] c_PTR_END  = c_PTR_W'(DIGITS);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DIGITS-1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(BUSY_TO-1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP-1);

`ifdef LCD_LZ_BLANK_EN
    localparam bit c_LZ = 1'b1;
`else
    localparam bit c_LZ = 1'b0;
`endif

    localparam logic [2:0] c_START   = 3'd0;
    localparam logic [2:0] c_FETCH   = 3'd1;
    localparam logic [2:0] c_LOAD    = 3'd2;
    localparam logic [2:0] c_ISSUE   = 3'd3;
    localparam logic [2:0] c_WAIT_HI = 3'd4;
    localparam logic [2:0] c_WAIT_LO = 3'd5;
    localparam logic [2:0] c_GAPS    = 3'd6;

    logic [2:0]           r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_TO_W-1:0]    r_to;
    logic [c_GAP_W-1:0]   r_gap;
    logic [MSG_W-1:0]     r_msg;
    logic [4*DIGITS-1:0]  r_snap;
    logic [ADDR_W-1:0]    r_rom_addr;
    logic                 r_lcd_ena;
    logic [9:0]           r_lcd_bus;
    logic                 r_frame_done;

    logic [MSG_W-1:0]     w_msg_eff;
    logic                 w_msg_chg;
    logic                 w_is_cmd;
    logic [7:0]           w_cmd;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic                 w_nxt_is_char;
    logic [ADDR_W-1:0]    w_addr_nxt;
    logic [3:0]           w_nib;
    logic                 w_lead;
    logic                 w_blank;
    logic [7:0]           w_char;

    assign w_msg_eff     = (int'(msg_sel) >= N_MSG) ? '0 : msg_sel;
    assign w_msg_chg     = (w_msg_eff != r_msg);
    assign w_is_cmd      = (r_idx == '0) || (r_idx == c_CMD2);
    assign w_cmd         = (r_idx == '0) ? 8'h80 : 8'hC0;
    assign w_idx_nxt     = r_idx + 1'b1;
    assign w_nxt_is_char = (w_idx_nxt != c_CMD2);
    // line 1 column c sits at idx c+1, line 2 column c at idx COLS+2+c
    assign w_addr_nxt    = ADDR_W'(int'(r_msg)*2*COLS + int'(w_idx_nxt)
                                   - ((w_idx_nxt > c_CMD2) ? 2 : 1));

    always_comb begin
        w_nib  = 4'h0;
        w_lead = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c_PTR_W'(i) == r_ptr)
                w_nib = r_snap[4*(DIGITS-1-i) +: 4];
            if ((c_PTR_W'(i) < r_ptr) && (r_snap[4*(DIGITS-1-i) +: 4] != 4'h0))
                w_lead = 1'b0;
        end
        w_blank = c_LZ && w_lead && (w_nib == 4'h0) && (r_ptr != c_PTR_LAST);
        if (rom_data != FIELD_CHAR)
            w_char = rom_data;
        else if (r_ptr >= c_PTR_END)
            w_char = 8'h20;
        else if (w_nib > 4'd9)
            w_char = 8'h3F;
        else if (w_blank)
            w_char = 8'h20;
        else
            w_char = {4'h3, w_nib};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_START;
            r_idx        <= '0;
            r_ptr        <= '0;
            r_to         <= '0;
            r_gap        <= '0;
            r_msg        <= '0;
            r_snap       <= '0;
            r_rom_addr   <= '0;
            r_lcd_ena    <= 1'b0;
            r_lcd_bus    <= 10'h000;
            r_frame_done <= 1'b0;
        end else begin
            r_lcd_ena    <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                c_START: begin
                    r_msg   <= w_msg_eff;
                    r_snap  <= value_bcd;
                    r_ptr   <= '0;
                    r_idx   <= '0;
                    r_state <= c_FETCH;
                end
                // never start a transfer while the controller is still busy
                c_FETCH: begin
                    if (!lcd_busy) begin
                        if (w_is_cmd) begin
                            r_lcd_bus <= {2'b00, w_cmd};
                            r_lcd_ena <= 1'b1;
                            r_state   <= c_ISSUE;
                        end else begin
                            r_state   <= c_LOAD;
                        end
                    end
                end
                c_LOAD: begin
                    r_lcd_bus <= {2'b10, w_char};
                    r_lcd_ena <= 1'b1;
                    if ((rom_data == FIELD_CHAR) && (r_ptr < c_PTR_END))
                        r_ptr <= r_ptr + 1'b1;
                    r_state <= c_ISSUE;
                end
                c_ISSUE: begin
                    r_to    <= '0;
                    r_state <= c_WAIT_HI;
                end
                c_WAIT_HI: begin
                    if (lcd_busy || (r_to == c_TO_LAST))
                        r_state <= c_WAIT_LO;
                    else
                        r_to <= r_to + 1'b1;
                end
                c_WAIT_LO: begin
                    if (!lcd_busy) begin
                        if (w_msg_chg) begin
                            r_state <= c_START;
                        end else if (r_idx == c_LAST) begin
                            r_frame_done <= 1'b1;
                            r_gap        <= '0;
                            r_state      <= (GAP == 0) ? c_START : c_GAPS;
                        end else begin
                            r_idx <= w_idx_nxt;
                            if (w_nxt_is_char)
                                r_rom_addr <= w_addr_nxt;
                            r_state <= c_FETCH;
                        end
                    end
                end
                c_GAPS: begin
                    if (w_msg_chg || (r_gap == c_GAP_LAST))
                        r_state <= c_START;
                    else
                        r_gap <= r_gap + 1'b1;
                end
                default: r_state <= c_START;
            endcase
        end
    end

    assign rom_addr   = r_rom_addr;
    assign lcd_ena    = r_lcd_ena;
    assign lcd_bus    = r_lcd_bus;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_text_sequencer
// Brief    : Scoreboard bench for lcd_text_sequencer with ROM model and busy BFM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_text_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lcd_busy = 1'b0;
    logic [1:0]  msg_sel = 2'd2;
    logic [15:0] value_bcd = 16'h0275;
    logic [6:0]  rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        lcd_ena;
    logic [9:0]  lcd_bus;
    logic        frame_done;

    logic [7:0]  rom [0:127];
    logic        bfm_quiet = 1'b0;
    int          bcnt = 0;

    logic [9:0]  exp_q[$];
    int          strobe_cyc [0:1023];
    int          strobes = 0;
    int          fd_count = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    string       l1_song, l2_temp_a, l2_temp_b, l1_zelda, l2_val;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_text_sequencer #(
        .N_MSG(4), .COLS(16), .DIGITS(4), .FIELD_CHAR(8'h01), .BUSY_TO(15), .GAP(8)
    ) dut (
        .clk(clk), .rst(rst), .lcd_busy(lcd_busy), .msg_sel(msg_sel),
        .value_bcd(value_bcd), .rom_addr(rom_addr), .rom_data(rom_data),
        .lcd_ena(lcd_ena), .lcd_bus(lcd_bus), .frame_done(frame_done)
    );

    always @(posedge clk) rom_data <= rom[rom_addr];

    // controller model: busy from the cycle after the strobe, for 5 cycles
    always @(posedge clk) begin
        if (bfm_quiet) begin
            lcd_busy <= 1'b0;
            bcnt     <= 0;
        end else if (lcd_ena === 1'b1) begin
            lcd_busy <= 1'b1;
            bcnt     <= 5;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else begin
            lcd_busy <= 1'b0;
            bcnt     <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && lcd_ena === 1'b1) begin
            logic [9:0] e;
            if (strobes < 1024) strobe_cyc[strobes] = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_%0d: lcd_bus got %03h, none expected", strobes, lcd_bus);
            end else begin
                e = exp_q.pop_front();
                if (lcd_bus !== e) begin
                    n_fail++;
                    $display("FAIL strobe_%0d: lcd_bus got %03h expected %03h", strobes, lcd_bus, e);
                end
            end
            strobes++;
        end
        if (rst === 1'b0 && frame_done === 1'b1) fd_count++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_line(input int m, input int l, input string s);
        for (int c = 0; c < 16; c++)
            rom[m*32 + l*16 + c] = (s[c] == 8'h40) ? 8'h01 : s[c];
    endtask

    function automatic logic [9:0] word_at(input int i, input string a, input string b);
        if (i == 0)  return 10'h080;
        if (i <= 16) return {2'b10, a[i-1]};
        if (i == 17) return 10'h0C0;
        return {2'b10, b[i-18]};
    endfunction

    task automatic push_frame(input string a, input string b, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(word_at(i, a, b));
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int k = 0;
        while (strobes < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (strobes < target) check("strobe_timeout", strobes, target);
    endtask

    task automatic wait_fd(input int target, input int budget);
        int k = 0;
        while (fd_count < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frame_done_count", fd_count, target);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        l1_song   = " Song of Storms ";
        l1_zelda  = "Zeldas Lullaby  ";
`ifdef LCD_LZ_BLANK_EN
        l2_temp_a = "  Temp:  27.5   ";
        l2_temp_b = "  Temp:  ?0.0   ";
        l2_val    = "Val  ?00  end   ";
`else
        l2_temp_a = "  Temp: 027.5   ";
        l2_temp_b = "  Temp: 0?0.0   ";
        l2_val    = "Val 0?00  end   ";
`endif
        for (int i = 0; i < 128; i++) rom[i] = 8'h23;
        load_line(2, 0, l1_song);
        load_line(2, 1, "  Temp: @@@.@   ");
        load_line(3, 0, l1_zelda);
        load_line(3, 1, "Val @@@@@ end   ");

        // reset state
        repeat (3) @(negedge clk);
        check("rst_lcd_ena", lcd_ena, 0);
        check("rst_lcd_bus", lcd_bus, 10'h000);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_frame_done", frame_done, 0);

        // frame 1: msg 2, value 0275
        push_frame(l1_song, l2_temp_a, 34);
        rst = 1'b0;
        wait_fd(1, 3000);

        // frame 2: value changes mid-frame, snapshot keeps old digits
        base = strobes;
        push_frame(l1_song, l2_temp_a, 34);
        wait_strobes(base + 5, 500);
        value_bcd = 16'h0A00;
        wait_fd(2, 3000);

        // frame 3: new value with non-BCD nibble
        push_frame(l1_song, l2_temp_b, 34);
        wait_fd(3, 3000);

        // frame 4: controller never goes busy, timeout paces the strobes
        bfm_quiet = 1'b1;
        base = strobes;
        push_frame(l1_song, l2_temp_b, 34);
        wait_strobes(base + 18, 2000);
        check("gap_cmd_to_char", strobe_cyc[base+1] - strobe_cyc[base], 19);
        check("gap_char_to_char", strobe_cyc[base+3] - strobe_cyc[base+2], 19);
        check("gap_char_to_cmd", strobe_cyc[base+17] - strobe_cyc[base+16], 18);
        wait_fd(4, 2000);
        bfm_quiet = 1'b0;

        // frame 5: msg switch at idx 10 restarts with msg 3, no frame_done
        base = strobes;
        push_frame(l1_song, l2_temp_b, 11);
        push_frame(l1_zelda, l2_val, 34);
        wait_strobes(base + 11, 500);
        msg_sel = 2'd3;
        wait_fd(5, 3000);

        // reset during WAIT_LO of the first transfer of the next frame
        base = strobes;
        push_frame(l1_zelda, l2_val, 1);
        wait_strobes(base + 1, 500);
        while (cyc < strobe_cyc[base] + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_lcd_ena", lcd_ena, 0);
        check("midrst_lcd_bus", lcd_bus, 10'h000);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_queue", exp_q.size(), 0);
        push_frame(l1_zelda, l2_val, 34);
        rst = 1'b0;
        wait_fd(6, 3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
